cmd_queue: RTL and testbench
============================

Name: cmd_queue

Overview:
- Command FIFO that sits directly upstream of the issuer.
- Accepts new commands from the host/core request path, and accepts writebacks from the issuer when a fetched command fails its scoreboard dependency check.
- Delivers commands to the issuer's CMD_GET/CMD_CHECK sequence with one-cycle registered read latency.
- Reserves slots for writebacks so that a requeued command is never lost.

Parameters:
- CMD_W, 64: width of one cmd_t word in bits.
- DEPTH, 16: number of entries; power of two, ≥ 4.
- RESERVE, 1: entries held back for writebacks only; 1 ≤ RESERVE < DEPTH.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_push_valid  in  1  host offers a new command.
- o_push_ready  out  1  host push accepted this cycle when high together with i_push_valid.
- i_push_cmd  in  CMD_W  host command.
- i_write  in  1  issuer writeback strobe (issuer o_write); single-cycle request, no ready.
- i_wb_cmd  in  CMD_W  writeback command (issuer o_cmd).
- i_read  in  1  issuer pop strobe (issuer o_read).
- o_cmd  out  CMD_W  registered head command (issuer i_cmd).
- o_cmd_valid  out  1  o_cmd was updated by a successful pop last cycle.
- i_flush  in  1  synchronous clear of all contents.
- o_empty  out  1  count == 0.
- o_full  out  1  count == DEPTH.
- o_count  out  $clog2(DEPTH)+1  current occupancy.
- o_wb_drop  out  1  sticky error: a writeback was discarded.

Behaviour:
- Reset (async, i_rstn low):
  - Pointers and count are 0.
  - o_cmd = 0, o_cmd_valid = 0, o_wb_drop = 0.
  - o_empty = 1, o_full = 0.
  - Memory contents are don't-care.
- Storage:
  - Circular buffer with write pointer, read pointer, and explicit count register.
  - Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Pop:
  - When i_read and count > 0 (registered count), the entry at the read pointer is loaded into o_cmd, the read pointer advances, and o_cmd_valid = 1 on the next cycle.
  - i_read on empty is ignored: o_cmd holds its value, o_cmd_valid = 0, no pointer change.
  - o_cmd holds between pops.
- Host push:
  - o_push_ready = (count < DEPTH-RESERVE) && !i_write && !i_flush.
  - Purely from registered count plus the two strobes; no path from i_read.
  - Accepted push writes i_push_cmd at the write pointer and advances it.
- Writeback:
  - Has priority over host push; host push is stalled in any cycle with i_write high.
  - Accepted when count < DEPTH, or when count == DEPTH and a valid pop occurs the same cycle.
  - Otherwise the writeback is dropped and o_wb_drop is set; it is cleared only by reset.
  - Accepted writeback is written at the tail, so it is reordered behind pending commands.
- Simultaneous events:
  - Pop plus one write in the same cycle: count unchanged, both pointers advance.
  - Writeback and host push in the same cycle: only the writeback is accepted.
  - Write to an empty queue: the entry becomes visible to a pop in the following cycle. There is no bypass, and o_cmd is never updated by a write.
- Count update: count_next = count + wr_accepted − rd_accepted. Never exceeds DEPTH and never goes below 0.
- Flush:
  - When i_flush is high, pointers and count go to 0 next cycle.
  - Pop, push and writeback in that cycle are all ignored; o_cmd_valid = 0.
  - o_cmd keeps its last value.
  - o_wb_drop is unaffected.
- Flags: o_empty, o_full and o_count are combinational decodes of the registered count.
- Reset mid-operation: all state returns immediately to reset values; in-flight pop data is lost.

Test Plan (DEPTH=4, RESERVE=1):
1. After reset, push 0xA1, 0xA2, 0xA3 on consecutive cycles -> o_push_ready drops after the third accept; o_count = 3; o_full = 0.
2. From scenario 1, pulse i_write with 0xB0 -> accepted; o_count = 4; o_full = 1. A following writeback 0xB1 with no read -> dropped, o_wb_drop = 1, o_count stays 4.
3. From full, i_read and i_write (0xC0) in the same cycle -> next cycle o_cmd = 0xA1, o_cmd_valid = 1, o_count = 4. Four further pops return 0xA2, 0xA3, 0xB0, 0xC0 in that order.
4. i_push_valid and i_write both high on an empty queue -> only the writeback entry is stored; o_count = 1; host push accepted the next cycle, giving o_count = 2.
5. i_read on empty -> o_cmd_valid stays 0 and o_cmd holds its previous value. Push 0x55 then i_read the next cycle -> o_cmd = 0x55 one cycle after the read.
6. Fill 3 entries, assert i_flush together with i_read -> o_count = 0, o_cmd_valid = 0, o_cmd unchanged. Then drive i_rstn low mid-push -> o_count = 0 and o_wb_drop = 0 asynchronously, with no entry retained.

Source files
------------

// File: rtl/cmd_queue.sv
// Command FIFO feeding the issuer: host pushes plus issuer writebacks, registered pop data.
// Latency: pop data appears one cycle after i_read; host push stalls when the reserved tail slots are reached.
module cmd_queue #(
  parameter int CMD_W   = 64,
  parameter int DEPTH   = 16,
  parameter int RESERVE = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_push_valid,
  output logic                       o_push_ready,
  input  logic [CMD_W-1:0]           i_push_cmd,
  input  logic                       i_write,
  input  logic [CMD_W-1:0]           i_wb_cmd,
  input  logic                       i_read,
  output logic [CMD_W-1:0]           o_cmd,
  output logic                       o_cmd_valid,
  input  logic                       i_flush,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_wb_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] HOST_LIM = CW'(DEPTH - RESERVE);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             cmd_vld_q, cmd_vld_d;
  logic             drop_q, drop_d;

  logic             rd_en;
  logic             wb_en;
  logic             push_en;
  logic             wr_en;
  logic [CMD_W-1:0] wr_dat;

  // Host readiness deliberately ignores i_read so the pop path never reaches the host.
  assign o_push_ready = (count_q < HOST_LIM) && !i_write && !i_flush;

  always_comb begin
    rd_en   = i_read && (count_q != '0) && !i_flush;
    // A full queue can still take a writeback if a pop frees the head slot this cycle.
    wb_en   = i_write && !i_flush && ((count_q != FULL_CNT) || rd_en);
    push_en = i_push_valid && o_push_ready;
    wr_en   = wb_en || push_en;
    wr_dat  = i_write ? i_wb_cmd : i_push_cmd;
  end

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    cmd_d     = cmd_q;
    cmd_vld_d = 1'b0;
    drop_d    = drop_q | (i_write && !i_flush && !wb_en);
    if (i_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) begin
        wptr_d = wptr_q + PTR_ONE;
      end
      if (rd_en) begin
        rptr_d    = rptr_q + PTR_ONE;
        cmd_d     = mem_q[rptr_q];
        cmd_vld_d = 1'b1;
      end
      count_d = count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      cmd_q     <= '0;
      cmd_vld_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      cmd_q     <= cmd_d;
      cmd_vld_q <= cmd_vld_d;
      drop_q    <= drop_d;
    end
  end

  // Storage has no reset; entries are only observable after being written.
  always_ff @(posedge i_clk) begin
    if (wr_en && !i_flush) begin
      mem_q[wptr_q] <= wr_dat;
    end
  end

  assign o_cmd       = cmd_q;
  assign o_cmd_valid = cmd_vld_q;
  assign o_wb_drop   = drop_q;
  assign o_count     = count_q;
  assign o_empty     = (count_q == '0);
  assign o_full      = (count_q == FULL_CNT);

endmodule

// File: tb/tb_cmd_queue.sv
module tb_cmd_queue;
  localparam int CMD_W = 64;
  localparam int DEPTH = 4;
  localparam int RES   = 1;

  logic             clk;
  logic             rstn;
  logic             push_valid;
  logic             push_ready;
  logic [CMD_W-1:0] push_cmd;
  logic             wr;
  logic [CMD_W-1:0] wb_cmd;
  logic             rd;
  logic [CMD_W-1:0] cmd;
  logic             cmd_valid;
  logic             flush;
  logic             empty;
  logic             full;
  logic [2:0]       count;
  logic             wb_drop;

  cmd_queue #(.CMD_W(CMD_W), .DEPTH(DEPTH), .RESERVE(RES)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_push_valid(push_valid), .o_push_ready(push_ready), .i_push_cmd(push_cmd),
    .i_write(wr), .i_wb_cmd(wb_cmd), .i_read(rd),
    .o_cmd(cmd), .o_cmd_valid(cmd_valid), .i_flush(flush),
    .o_empty(empty), .o_full(full), .o_count(count), .o_wb_drop(wb_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference contents of the queue, and expected pop outputs in order.
  logic [CMD_W-1:0] model_q [$];
  logic [CMD_W-1:0] exp_q   [$];
  logic             rdy_seen;

  task automatic drive(input logic pv, input logic [CMD_W-1:0] pc,
                       input logic w, input logic [CMD_W-1:0] wc,
                       input logic r, input logic f);
    int  n;
    bit  rd_acc, wb_acc, push_acc;
    push_valid = pv; push_cmd = pc; wr = w; wb_cmd = wc; rd = r; flush = f;
    #1;
    rdy_seen = push_ready;
    n        = model_q.size();
    rd_acc   = r && (n > 0) && !f;
    wb_acc   = w && !f && ((n < DEPTH) || rd_acc);
    push_acc = pv && (n < DEPTH - RES) && !w && !f;
    @(posedge clk);
    #1;
    if (f) begin
      model_q.delete();
    end else begin
      if (rd_acc) exp_q.push_back(model_q.pop_front());
      if (wb_acc) model_q.push_back(wc);
      else if (push_acc) model_q.push_back(pc);
    end
    push_valid = 1'b0; wr = 1'b0; rd = 1'b0; flush = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_bad++; $display("FAIL reset_flags: empty=%b full=%b want 1/0", empty, full); end
    n_cmp++; if (cmd !== '0 || cmd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_cmd: cmd=%h vld=%b want 0/0", cmd, cmd_valid); end
    n_cmp++; if (wb_drop !== 1'b0) begin n_bad++; $display("FAIL reset_drop: got %b want 0", wb_drop); end
    n_cmp++; if (push_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", push_ready); end
  endtask

  task automatic test_fill();
    logic [CMD_W-1:0] vals [3];
    vals[0] = 64'hA1; vals[1] = 64'hA2; vals[2] = 64'hA3;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vals[i], 1'b0, '0, 1'b0, 1'b0);
      n_cmp++; if (rdy_seen !== 1'b1) begin n_bad++; $display("FAIL fill_ready%0d: got %b want 1", i, rdy_seen); end
    end
    n_cmp++; if (push_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready_drop: got %b want 0", push_ready); end
    n_cmp++; if (count !== 3'd3 || full !== 1'b0) begin n_bad++; $display("FAIL fill_count: count=%0d full=%b want 3/0", count, full); end
  endtask

  task automatic test_wb_full();
    drive(1'b0, '0, 1'b1, 64'hB0, 1'b0, 1'b0);
    n_cmp++; if (count !== 3'd4 || full !== 1'b1) begin n_bad++; $display("FAIL wb_accept: count=%0d full=%b want 4/1", count, full); end
    n_cmp++; if (wb_drop !== 1'b0) begin n_bad++; $display("FAIL wb_no_drop: got %b want 0", wb_drop); end
    drive(1'b0, '0, 1'b1, 64'hB1, 1'b0, 1'b0);
    n_cmp++; if (wb_drop !== 1'b1) begin n_bad++; $display("FAIL wb_drop: got %b want 1", wb_drop); end
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL wb_drop_count: got %0d want 4", count); end
  endtask

  task automatic test_pop_wb_full();
    logic [CMD_W-1:0] e;
    drive(1'b0, '0, 1'b1, 64'hC0, 1'b1, 1'b0);
    n_cmp++; if (cmd !== 64'hA1 || cmd_valid !== 1'b1) begin n_bad++; $display("FAIL popwb_head: cmd=%h vld=%b want a1/1", cmd, cmd_valid); end
    void'(exp_q.pop_front());
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL popwb_count: got %0d want 4", count); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      n_cmp++; if (cmd_valid !== 1'b1 || cmd !== e) begin n_bad++; $display("FAIL popwb_drain%0d: cmd=%h vld=%b want %h/1", i, cmd, cmd_valid, e); end
    end
    n_cmp++; if (cmd !== 64'hC0) begin n_bad++; $display("FAIL popwb_last: got %h want c0", cmd); end
    n_cmp++; if (empty !== 1'b1 || count !== 3'd0) begin n_bad++; $display("FAIL popwb_empty: empty=%b count=%0d want 1/0", empty, count); end
    n_cmp++; if (wb_drop !== 1'b1) begin n_bad++; $display("FAIL drop_sticky: got %b want 1", wb_drop); end
  endtask

  task automatic test_priority();
    logic [CMD_W-1:0] e;
    drive(1'b1, 64'h11, 1'b1, 64'h22, 1'b0, 1'b0);
    n_cmp++; if (rdy_seen !== 1'b0) begin n_bad++; $display("FAIL prio_ready: got %b want 0", rdy_seen); end
    n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL prio_count1: got %0d want 1", count); end
    drive(1'b1, 64'h11, 1'b0, '0, 1'b0, 1'b0);
    n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL prio_count2: got %0d want 2", count); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      n_cmp++; if (cmd_valid !== 1'b1 || cmd !== e) begin n_bad++; $display("FAIL prio_pop%0d: cmd=%h vld=%b want %h/1", i, cmd, cmd_valid, e); end
    end
  endtask

  task automatic test_empty_read();
    logic [CMD_W-1:0] e;
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (cmd_valid !== 1'b0 || cmd !== 64'h11) begin n_bad++; $display("FAIL empty_read: cmd=%h vld=%b want 11/0", cmd, cmd_valid); end
    drive(1'b1, 64'h55, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    n_cmp++; if (cmd_valid !== 1'b1 || cmd !== e || cmd !== 64'h55) begin n_bad++; $display("FAIL push_pop55: cmd=%h vld=%b want 55/1", cmd, cmd_valid); end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    n_cmp++; if (cmd_valid !== 1'b0 || cmd !== 64'h55) begin n_bad++; $display("FAIL hold55: cmd=%h vld=%b want 55/0", cmd, cmd_valid); end
    // No bypass: push and read together on an empty queue must not pop.
    drive(1'b1, 64'h66, 1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (cmd_valid !== 1'b0 || cmd !== 64'h55 || count !== 3'd1) begin n_bad++; $display("FAIL no_bypass: cmd=%h vld=%b count=%0d want 55/0/1", cmd, cmd_valid, count); end
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    n_cmp++; if (cmd_valid !== 1'b1 || cmd !== e) begin n_bad++; $display("FAIL pop66: cmd=%h vld=%b want %h/1", cmd, cmd_valid, e); end
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 64'h71 + 64'(i), 1'b0, '0, 1'b0, 1'b0);
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL flush_pre: got %0d want 3", count); end
    drive(1'b0, '0, 1'b1, 64'hEE, 1'b1, 1'b1);
    n_cmp++; if (count !== 3'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL flush_count: count=%0d empty=%b want 0/1", count, empty); end
    n_cmp++; if (cmd_valid !== 1'b0 || cmd !== 64'h66) begin n_bad++; $display("FAIL flush_cmd: cmd=%h vld=%b want 66/0", cmd, cmd_valid); end
    n_cmp++; if (wb_drop !== 1'b1) begin n_bad++; $display("FAIL flush_drop: got %b want 1", wb_drop); end
    drive(1'b1, 64'h81, 1'b0, '0, 1'b0, 1'b0);
    push_valid = 1'b1; push_cmd = 64'h82;
    #1;
    rstn = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd0 || wb_drop !== 1'b0 || cmd !== '0) begin n_bad++; $display("FAIL async_rst: count=%0d drop=%b cmd=%h want 0/0/0", count, wb_drop, cmd); end
    push_valid = 1'b0;
    model_q.delete();
    exp_q.delete();
    @(posedge clk);
    #2;
    rstn = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (count !== 3'd0 || empty !== 1'b1 || cmd_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst: count=%0d empty=%b vld=%b want 0/1/0", count, empty, cmd_valid); end
  endtask

  initial begin
    rstn = 1'b0; push_valid = 1'b0; push_cmd = '0; wr = 1'b0; wb_cmd = '0;
    rd = 1'b0; flush = 1'b0; rdy_seen = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    test_reset();
    rstn = 1'b1;
    @(posedge clk);
    #2;
    test_fill();
    test_wb_full();
    test_pop_wb_full();
    test_priority();
    test_empty_read();
    test_flush_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
